// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 types, command codes and timing helper
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SHIFT,
        ACK,
        RELEASE
    } ps2_tx_state_t;

    localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;

    function automatic int us_to_cycles(input int us, input int clk_hz);
        longint prod;
        prod = longint'(us) * longint'(clk_hz);
        return int'(prod / longint'(1_000_000));
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - PS/2 clock/data synchronizer with falling-edge detect
module ps2_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic ps2_clk_in,
    input  logic ps2_data_in,
    output logic clk_sync,
    output logic data_sync,
    output logic clk_fall,
    output logic data_fall
);

    logic [SYNC_STAGES-1:0] clk_pipe;
    logic [SYNC_STAGES-1:0] data_pipe;
    logic                   clk_prev;
    logic                   data_prev;

    // Idle bus level is high, so reset the chain high to avoid a false edge.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            clk_pipe  <= '1;
            data_pipe <= '1;
            clk_prev  <= 1'b1;
            data_prev <= 1'b1;
        end else begin
            clk_pipe  <= {clk_pipe[SYNC_STAGES-2:0], ps2_clk_in};
            data_pipe <= {data_pipe[SYNC_STAGES-2:0], ps2_data_in};
            clk_prev  <= clk_sync;
            data_prev <= data_sync;
        end
    end

    assign clk_sync  = clk_pipe[SYNC_STAGES-1];
    assign data_sync = data_pipe[SYNC_STAGES-1];
    assign clk_fall  = clk_prev & ~clk_sync;
    assign data_fall = data_prev & ~data_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter with ACK check
// Build option PS2_TX_AUTO_INIT_EN: self-issue 8'hF4 once after reset, retrying once on error.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 74_250_000,
    parameter int INHIBIT_US  = 120,
    parameter int TIMEOUT_MS  = 15,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       busy_out,
    output logic       done_out,
    output logic       ack_ok_out,
    output logic       error_out,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe_out,
    output logic       ps2_data_oe_out
);

    localparam int INH_CYC = us_to_cycles(INHIBIT_US, CLK_FREQ_HZ);
    localparam int INH_W   = $clog2(INH_CYC) + 1;
    localparam int WD_CYC  = us_to_cycles(TIMEOUT_MS * 1000, CLK_FREQ_HZ);
    localparam int WD_W    = $clog2(WD_CYC) + 1;

    localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INH_CYC - 1);
    localparam logic [WD_W-1:0]  WD_LOAD  = WD_W'(WD_CYC - 1);

    ps2_tx_state_t    state, state_d;
    logic [10:0]      shreg, shreg_d;
    logic [3:0]       bitcnt, bitcnt_d;
    logic [INH_W-1:0] inh_cnt, inh_cnt_d;
    logic [WD_W-1:0]  wd_cnt, wd_cnt_d;
    logic             clk_oe, clk_oe_d;
    logic             data_oe, data_oe_d;
    logic             done, done_d;
    logic             ack_ok, ack_ok_d;
    logic             error, error_d;
    logic             start;
    logic [7:0]       start_byte;
    logic             wd_expired;

    logic             clk_sync;
    logic             data_sync;
    logic             clk_fall;
    logic             data_fall_unused;

`ifdef PS2_TX_AUTO_INIT_EN
    logic             init_active, init_active_d;
    logic             retry_used, retry_used_d;
`endif

    ps2_line_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_line_sync (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .clk_sync    (clk_sync),
        .data_sync   (data_sync),
        .clk_fall    (clk_fall),
        .data_fall   (data_fall_unused)
    );

    assign wd_expired = (wd_cnt == '0);

    always_comb begin
        state_d    = state;
        shreg_d    = shreg;
        bitcnt_d   = bitcnt;
        inh_cnt_d  = inh_cnt;
        wd_cnt_d   = wd_expired ? wd_cnt : wd_cnt - WD_W'(1);
        clk_oe_d   = clk_oe;
        data_oe_d  = data_oe;
        done_d     = 1'b0;
        ack_ok_d   = ack_ok;
        error_d    = error;
        start      = valid_in && ready_out;
        start_byte = data_in;
`ifdef PS2_TX_AUTO_INIT_EN
        init_active_d = init_active;
        retry_used_d  = retry_used;
        if (state == IDLE && init_active) begin
            start      = 1'b1;
            start_byte = PS2_CMD_ENABLE;
        end
`endif

        // Once the device is expected to clock, a silent bus aborts the frame.
        if (wd_expired && (state == RTS || state == SHIFT || state == ACK)) begin
            state_d   = RELEASE;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            error_d   = 1'b1;
            wd_cnt_d  = WD_LOAD;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_d   = INHIBIT;
                        shreg_d   = {1'b1, ~^start_byte, start_byte, 1'b0};
                        bitcnt_d  = 4'd0;
                        inh_cnt_d = INH_LOAD;
                        clk_oe_d  = 1'b1;
                        data_oe_d = 1'b0;
                        ack_ok_d  = 1'b0;
                        error_d   = 1'b0;
                    end
                end
                INHIBIT: begin
                    if (inh_cnt == '0) begin
                        // Clock release and start bit share one update so both oe are never high together.
                        state_d   = RTS;
                        clk_oe_d  = 1'b0;
                        data_oe_d = ~shreg[0];
                        bitcnt_d  = 4'd1;
                        wd_cnt_d  = WD_LOAD;
                    end else begin
                        inh_cnt_d = inh_cnt - INH_W'(1);
                    end
                end
                RTS: begin
                    state_d = SHIFT;
                end
                SHIFT: begin
                    if (clk_fall) begin
                        data_oe_d = ~shreg[bitcnt];
                        wd_cnt_d  = WD_LOAD;
                        if (bitcnt == 4'd10) begin
                            state_d = ACK;
                        end else begin
                            bitcnt_d = bitcnt + 4'd1;
                        end
                    end
                end
                ACK: begin
                    if (clk_fall) begin
                        wd_cnt_d = WD_LOAD;
                        state_d  = RELEASE;
                        if (!data_sync) begin
                            ack_ok_d = 1'b1;
                        end else begin
                            error_d = 1'b1;
                        end
                    end
                end
                RELEASE: begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    if (clk_sync && data_sync) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (wd_expired) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        error_d = 1'b1;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                end
            endcase
        end

`ifdef PS2_TX_AUTO_INIT_EN
        if (done_d && init_active) begin
            if (error_d && !retry_used) begin
                retry_used_d = 1'b1;
            end else begin
                init_active_d = 1'b0;
            end
        end
`endif
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state   <= IDLE;
            shreg   <= '0;
            bitcnt  <= 4'd0;
            inh_cnt <= '0;
            wd_cnt  <= '0;
            clk_oe  <= 1'b0;
            data_oe <= 1'b0;
            done    <= 1'b0;
            ack_ok  <= 1'b0;
            error   <= 1'b0;
`ifdef PS2_TX_AUTO_INIT_EN
            init_active <= 1'b1;
            retry_used  <= 1'b0;
`endif
        end else begin
            state   <= state_d;
            shreg   <= shreg_d;
            bitcnt  <= bitcnt_d;
            inh_cnt <= inh_cnt_d;
            wd_cnt  <= wd_cnt_d;
            clk_oe  <= clk_oe_d;
            data_oe <= data_oe_d;
            done    <= done_d;
            ack_ok  <= ack_ok_d;
            error   <= error_d;
`ifdef PS2_TX_AUTO_INIT_EN
            init_active <= init_active_d;
            retry_used  <= retry_used_d;
`endif
        end
    end

`ifdef PS2_TX_AUTO_INIT_EN
    assign ready_out = (state == IDLE) && !init_active;
`else
    assign ready_out = (state == IDLE);
`endif
    assign busy_out        = (state != IDLE);
    assign done_out        = done;
    assign ack_ok_out      = ack_ok;
    assign error_out       = error;
    assign ps2_clk_oe_out  = clk_oe;
    assign ps2_data_oe_out = data_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - scoreboard bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH_CYC = 120;
    localparam int WD_CYC  = 15000;
    localparam int H       = 40;

    typedef struct {
        logic [10:0] frame;
        bit          chk_frame;
        logic        ack;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  data = 8'h00;
    logic        valid = 1'b0;
    logic        ready, busy, done, ack_ok, err, clk_oe, data_oe;
    logic        dev_clk = 1'b1;
    logic        dev_data = 1'b1;
    logic        ps2_clk, ps2_data;
    logic [10:0] dev_cap = '1;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          overlap = 0;
    int          cyc = 0;

    assign ps2_clk  = ~clk_oe & dev_clk;
    assign ps2_data = ~data_oe & dev_data;

    ps2_host_tx #(
        .CLK_FREQ_HZ (1_000_000),
        .INHIBIT_US  (120),
        .TIMEOUT_MS  (15),
        .SYNC_STAGES (2)
    ) dut (
        .clk_in          (clk),
        .rst_in          (rst_n),
        .data_in         (data),
        .valid_in        (valid),
        .ready_out       (ready),
        .busy_out        (busy),
        .done_out        (done),
        .ack_ok_out      (ack_ok),
        .error_out       (err),
        .ps2_clk_in      (ps2_clk),
        .ps2_data_in     (ps2_data),
        .ps2_clk_oe_out  (clk_oe),
        .ps2_data_oe_out (data_oe)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic fail_bound(input string name);
        checks++;
        errors++;
        $display("FAIL %s wait bound expired", name);
    endtask

    task automatic push_exp(input logic [10:0] f, input bit c, input logic a, input logic e);
        exp_q.push_back('{f, c, a, e});
    endtask

    task automatic issue(input logic [7:0] b);
        int n = 0;
        while (!ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) fail_bound("ready_wait");
        data  = b;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 30000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 30000) fail_bound(name);
        @(negedge clk);
    endtask

    // Device side: clocks nfalls bits, sampling each just before the rising edge.
    task automatic dev_run(input bit do_ack, input int nfalls);
        int n = 0;
        while (!(ps2_clk && !ps2_data) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            fail_bound("rts_wait");
            return;
        end
        dev_cap    = '1;
        dev_cap[0] = ps2_data;
        repeat (H) @(negedge clk);
        for (int k = 1; k <= nfalls; k++) begin
            dev_clk = 1'b0;
            repeat (H) @(negedge clk);
            dev_cap[k] = ps2_data;
            dev_clk = 1'b1;
            repeat (H) @(negedge clk);
        end
        if (nfalls >= 10) begin
            if (do_ack) dev_data = 1'b0;
            repeat (H / 2) @(negedge clk);
            dev_clk = 1'b0;
            repeat (H) @(negedge clk);
            dev_clk = 1'b1;
            repeat (H / 2) @(negedge clk);
            dev_data = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        if (clk_oe && data_oe) overlap++;
        if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual done_out=1 required no pending command");
            end else begin
                mon_e = exp_q.pop_front();
                chk("ack_ok", ack_ok, mon_e.ack);
                chk("error", err, mon_e.err);
                if (mon_e.chk_frame) chk("wire_frame", dev_cap, mon_e.frame);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout actual still running required finish");
        $fatal(1);
    end

    initial begin
        int n, t0, t1, d;

        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ack_ok", ack_ok, 0);
        chk("rst_error", err, 0);
        chk("rst_clk_oe", clk_oe, 0);
        chk("rst_data_oe", data_oe, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Enable reporting: parity 0
        push_exp(11'b1_0_11110100_0, 1, 1'b1, 1'b0);
        issue(PS2_CMD_ENABLE);
        chk("busy_after_accept", busy, 1);
        chk("ready_after_accept", ready, 0);
        n = 0;
        while (clk_oe && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("inhibit_cycles", n, INH_CYC);
        dev_run(1'b1, 10);
        wait_idle("idle_f4");
        chk("done_count_f4", done_cnt, 1);

        push_exp(11'b1_1_11111111_0, 1, 1'b1, 1'b0);
        issue(PS2_CMD_RESET);
        dev_run(1'b1, 10);
        wait_idle("idle_ff");
        push_exp(11'b1_1_00000000_0, 1, 1'b1, 1'b0);
        issue(8'h00);
        dev_run(1'b1, 10);
        wait_idle("idle_00");
        chk("done_count_ff_00", done_cnt, 3);

        // Device leaves data high on the ACK clock
        push_exp(11'b1_1_01010101_0, 1, 1'b0, 1'b1);
        issue(8'h55);
        dev_run(1'b0, 10);
        wait_idle("idle_nack");
        chk("nack_clk_oe", clk_oe, 0);
        chk("nack_data_oe", data_oe, 0);

        // Device never clocks
        push_exp(11'h000, 0, 1'b0, 1'b1);
        issue(8'hAA);
        n = 0;
        while (!data_oe && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) fail_bound("rts_start");
        t0 = cyc;
        n = 0;
        while (!err && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) fail_bound("timeout_error");
        t1 = cyc;
        d = t1 - t0;
        checks++;
        if (d < WD_CYC - 1 || d > WD_CYC + 1) begin
            errors++;
            $display("FAIL timeout_cycles actual %0d required %0d+/-1", d, WD_CYC);
        end
        wait_idle("idle_timeout");
        chk("timeout_clk_oe", clk_oe, 0);
        chk("timeout_data_oe", data_oe, 0);
        chk("done_count_timeout", done_cnt, 5);

        // Reset mid-frame after the 4th data bit
        issue(8'h3C);
        dev_run(1'b1, 4);
        rst_n = 1'b0;
        #1;
        chk("midrst_clk_oe", clk_oe, 0);
        chk("midrst_data_oe", data_oe, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_ready", ready, 1);
        push_exp(11'b1_1_10100101_0, 1, 1'b1, 1'b0);
        issue(8'hA5);
        dev_run(1'b1, 10);
        wait_idle("idle_after_rst");
        chk("done_count_after_rst", done_cnt, 6);

        // valid_in while busy is dropped
        push_exp(11'b1_0_00000001_0, 1, 1'b1, 1'b0);
        issue(8'h01);
        repeat (10) @(negedge clk);
        data  = 8'hED;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        chk("ready_while_busy", ready, 0);
        dev_run(1'b1, 10);
        wait_idle("idle_busy_drop");
        repeat (300) @(negedge clk);
        chk("busy_after_drop", busy, 0);
        chk("done_count_final", done_cnt, 7);

        chk("oe_overlap_cycles", overlap, 0);
        chk("exp_queue_left", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
